// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 4-input round-robin arbiter.
package rr_arb_pkg;

  typedef logic [1:0] src_t;

  localparam int unsigned N_IN = 4;

  // Wraps 3 -> 0 through the natural 2-bit overflow.
  function automatic src_t next_idx(src_t i);
    return i + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arb_if.sv
// Handshake bundle between four producers, the arbiter and the downstream consumer.
interface rr_arb_if
  import rr_arb_pkg::*;
#(
  parameter int unsigned W = 4
) ();

  logic [N_IN-1:0] up_vld;
  logic [N_IN-1:0] up_rdy;
  logic [W-1:0]    d0;
  logic [W-1:0]    d1;
  logic [W-1:0]    d2;
  logic [W-1:0]    d3;
  logic            down_vld;
  logic            down_rdy;
  logic [W-1:0]    down_data;
  src_t            down_src;

  modport master (
    output up_vld, d0, d1, d2, d3, down_rdy,
    input  up_rdy, down_vld, down_data, down_src
  );

  modport slave (
    input  up_vld, d0, d1, d2, d3, down_rdy,
    output up_rdy, down_vld, down_data, down_src
  );

endinterface

// File: rtl/rr_pick_4.sv
// Combinational rotating-priority pick: first valid index after last, wrapping mod 4.
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [N_IN-1:0] up_vld,
  input  src_t            last,
  output src_t            sel,
  output logic            any_vld
);

  src_t idx;
  logic found;

  always_comb begin
    sel     = next_idx(last);
    any_vld = |up_vld;
    found   = 1'b0;
    idx     = last;
    for (int k = 0; k < int'(N_IN); k++) begin
      idx = next_idx(idx);
      if (!found && up_vld[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_4.sv
// Round-robin arbiter over four producers feeding a single registered output stage.
module rr_arb_4
  import rr_arb_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  rr_arb_if.slave bus
);

  logic         down_vld_q, down_vld_d;
  logic [W-1:0] down_data_q, down_data_d;
  src_t         down_src_q, down_src_d;
  src_t         last_q, last_d;

  src_t         sel;
  logic         any_vld;
  logic         can_load;
  logic         grant;
  logic [W-1:0] sel_data;

  rr_pick_4 u_pick (
    .up_vld  (bus.up_vld),
    .last    (last_q),
    .sel     (sel),
    .any_vld (any_vld)
  );

  always_comb begin
    can_load = !down_vld_q || bus.down_rdy;
    // Gating with rst_n keeps up_rdy low while reset is asserted.
    grant    = rst_n && can_load && any_vld;
    sel_data = sel[1] ? (sel[0] ? bus.d3 : bus.d2) : (sel[0] ? bus.d1 : bus.d0);
    bus.up_rdy = '0;
    if (grant) begin
      bus.up_rdy[sel] = 1'b1;
    end
  end

  always_comb begin
    down_vld_d  = down_vld_q;
    down_data_d = down_data_q;
    down_src_d  = down_src_q;
    last_d      = last_q;
    if (grant) begin
      down_vld_d  = 1'b1;
      down_data_d = sel_data;
      down_src_d  = sel;
      last_d      = sel;
    end else if (down_vld_q && bus.down_rdy) begin
      down_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      down_vld_q  <= 1'b0;
      down_data_q <= '0;
      down_src_q  <= '0;
      last_q      <= 2'd3;
    end else begin
      down_vld_q  <= down_vld_d;
      down_data_q <= down_data_d;
      down_src_q  <= down_src_d;
      last_q      <= last_d;
    end
  end

  assign bus.down_vld  = down_vld_q;
  assign bus.down_data = down_data_q;
  assign bus.down_src  = down_src_q;

endmodule

// File: tb/tb_rr_arb_4.sv
// Scoreboard bench for rr_arb_4: directed scenarios followed by randomized traffic.
module tb_rr_arb_4;
  import rr_arb_pkg::*;

  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] data;
    int           src;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arb_if #(.W(W)) bus ();

  rr_arb_4 #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  int   m_last = 3;
  bit   m_vld = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, predict from the model, then advance past the edge.
  task automatic drive(logic [3:0] vld, logic rdy, logic [W-1:0] a, logic [W-1:0] b,
                       logic [W-1:0] c, logic [W-1:0] d, logic rst);
    logic [W-1:0] dv [4];
    logic [3:0]   exp_rdy;
    int           sel;
    dv = '{a, b, c, d};
    bus.up_vld   = vld;
    bus.down_rdy = rdy;
    bus.d0 = a;
    bus.d1 = b;
    bus.d2 = c;
    bus.d3 = d;
    rst_n  = rst;
    #1;
    exp_rdy = 4'b0000;
    sel     = -1;
    if (rst) begin
      if (!m_vld || rdy) begin
        for (int k = 1; k <= 4; k++) begin
          if (sel < 0 && vld[(m_last + k) % 4]) sel = (m_last + k) % 4;
        end
      end
      if (sel >= 0) exp_rdy[sel] = 1'b1;
    end
    chk("up_rdy", 32'(bus.up_rdy), 32'(exp_rdy));
    if (rst) begin
      if (sel >= 0) begin
        q.push_back('{data: dv[sel], src: sel});
        m_last = sel;
        m_vld  = 1'b1;
      end else if (m_vld && rdy) begin
        m_vld = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      m_vld  = 1'b0;
      m_last = 3;
      q.delete();
      chk("rst_down_vld", 32'(bus.down_vld), 32'(0));
      chk("rst_down_data", 32'(bus.down_data), 32'(0));
      chk("rst_down_src", 32'(bus.down_src), 32'(0));
    end else begin
      chk("down_vld", 32'(bus.down_vld), 32'(m_vld));
    end
  endtask

  // Monitor: the held word must match the queue head; pop on a downstream handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.down_vld === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL orphan_word: got src %0d data %0h, expected no word at %0t",
                 bus.down_src, bus.down_data, $time);
      end else begin
        chk("down_data", 32'(bus.down_data), 32'(q[0].data));
        chk("down_src", 32'(bus.down_src), 32'(q[0].src));
        if (bus.down_rdy === 1'b1) void'(q.pop_front());
      end
    end
  end

  localparam logic [W-1:0] XW = {W{1'bx}};

  initial begin
    logic [3:0]   v;
    logic         r;
    logic [W-1:0] dd [4];

    // Reset, then idle
    drive(4'b0000, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    drive(4'b0000, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) drive(4'b0000, 1'b1, XW, XW, XW, XW, 1'b1);

    // Rotation: all valid, 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 1'b1, 4'ha, 4'hb, 4'hc, 4'hd, 1'b1);
      chk("rot_src", 32'(bus.down_src), 32'(i % 4));
    end

    // Sparse requests on inputs 0 and 2
    for (int i = 0; i < 4; i++) drive(4'b0101, 1'b1, 4'h7, XW, 4'h3, XW, 1'b1);

    // Stall holding src 1, then next grant must be src 2
    drive(4'b0010, 1'b1, XW, 4'hb, XW, XW, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, 1'b0, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
      chk("stall_data", 32'(bus.down_data), 32'(4'hb));
      chk("stall_src", 32'(bus.down_src), 32'(1));
    end
    drive(4'b1111, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    chk("post_stall_src", 32'(bus.down_src), 32'(2));

    // Drain and wrap: src 3 with X data, then src 0, then idle drains
    drive(4'b1000, 1'b1, XW, XW, XW, XW, 1'b1);
    drive(4'b0001, 1'b1, 4'h5, XW, XW, XW, 1'b1);
    chk("wrap_src", 32'(bus.down_src), 32'(0));
    drive(4'b0000, 1'b1, XW, XW, XW, XW, 1'b1);
    drive(4'b0000, 1'b1, XW, XW, XW, XW, 1'b1);

    // Reset mid-operation while stalled
    drive(4'b0100, 1'b1, XW, XW, 4'h9, XW, 1'b1);
    drive(4'b1111, 1'b0, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    drive(4'b1111, 1'b0, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
    drive(4'b1111, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    chk("post_rst_src", 32'(bus.down_src), 32'(0));

    // Randomized traffic; unrequested inputs carry X
    for (int i = 0; i < 800; i++) begin
      v = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) dd[k] = v[k] ? W'($urandom) : XW;
      drive(v, r, dd[0], dd[1], dd[2], dd[3], ($urandom_range(0, 99) != 0));
    end

    for (int i = 0; i < 3; i++) drive(4'b0000, 1'b1, XW, XW, XW, XW, 1'b1);
    chk("queue_empty", 32'(q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
